gyrator_tune_ctrl: RTL
======================

# gyrator_tune_ctrl

Digital tuning controller for the op-amp gyrator (synthesized inductor L = R1·R2·C). It sets the gyrator's programmable resistor through a serial digipot. It trims the resistor code by successive approximation until a measured impedance value matches a target. The block sits between the digipot, the impedance-measurement front end and the host.

## Interface

**Parameters**
- `CODE_W`, 8: digipot code width; one SAR iteration per bit.
- `SETTLE_CYCLES`, 64: wait after each pot write before measuring (≥1).
- `SCLK_DIV`, 4: clk cycles per SCLK half-period (≥1).
- `TIMEOUT`, 1024: maximum cycles waiting for `meas_ack`.

**Ports**
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: one-cycle request to begin tuning; honoured only when IDLE.
- `target`, in, 16: desired measurement value, unsigned; sampled on accepted `start`.
- `meas_req`, out, 1: measurement request; held high until `meas_ack`.
- `meas_ack`, in, 1: measurement valid strobe.
- `meas_val`, in, 16: measured value, unsigned; valid with `meas_ack`.
- `pot_cs_n`, out, 1: digipot chip select, active low.
- `pot_sclk`, out, 1: digipot serial clock; idles low.
- `pot_sdi`, out, 1: digipot serial data, MSB first.
- `code`, out, CODE_W: current or final code.
- `busy`, out, 1: high from accepted `start` until DONE or FAIL is entered.
- `done`, out, 1: one-cycle pulse on successful completion.
- `fail`, out, 1: sticky measurement-timeout flag; cleared by the next accepted `start` or by `rst`.

## Operation

**Reset values**
- `code` = 0; `busy`, `done`, `fail`, `meas_req`, `pot_sclk`, `pot_sdi` = 0; `pot_cs_n` = 1.
- State = IDLE.

**Assumption on the measurement**
- `meas_val` increases monotonically with `code`.

**States**
- **IDLE**: on `start`, latch `target`, clear `fail`, set `bit_idx` = CODE_W−1, `code` = 1<<(CODE_W−1), go to WRITE.
- **WRITE**: shift a 16-bit frame {8'h11, code zero-extended or truncated to 8 bits}. At end of frame: go to SETTLE, or to DONE if the `final` flag is set.
- **SETTLE**: count SETTLE_CYCLES, then go to MEAS.
- **MEAS**: assert `meas_req`, start the timeout counter.
  - `meas_ack` seen: drop `meas_req` that cycle, go to DECIDE.
  - Counter reaches TIMEOUT without `meas_ack`: set `fail`, drop `meas_req`, go to FAIL.
- **DECIDE**:
  - If `meas_val` > target, clear `code[bit_idx]`; equal keeps the bit.
  - If `bit_idx` == 0: set `final`, go to WRITE so the resolved code is written.
  - Otherwise: decrement `bit_idx`, set `code[bit_idx−1]`, go to WRITE.
- **DONE**: pulse `done` for one cycle, clear `busy` and `final`, go to IDLE.
- **FAIL**: clear `busy`, go to IDLE. `code` holds the last trial value.

**Boundary rules**
- `start` while busy is ignored.
- `meas_ack` outside MEAS is ignored.
- `meas_ack` in the same cycle as timeout expiry counts as success.
- `rst` mid-frame forces `pot_cs_n` high immediately on the next edge and aborts the frame; the pot keeps its previous value.
- The comparison is unsigned 16-bit.

## Timing

**SPI frame**
- `pot_cs_n` falls on WRITE entry with `pot_sdi` = frame bit 15.
- `pot_sclk` toggles every SCLK_DIV cycles, starting low.
- `pot_sdi` updates on each falling SCLK.
- Frame ends after the 16th falling edge. `pot_cs_n` rises that same cycle.
- `pot_cs_n` is low for exactly 32·SCLK_DIV cycles.

**Per-iteration latency**
- 32·SCLK_DIV + SETTLE_CYCLES + (measurement response) + 1 (DECIDE) cycles.
- Final write adds 32·SCLK_DIV cycles; `done` follows 1 cycle after the final `pot_cs_n` rise.

**Other timing**
- `meas_req` rises on the first cycle of MEAS.
- `busy` rises the cycle after accepted `start`.

## Test plan

- **Reset:** assert `rst` 3 cycles → all outputs at reset values, `pot_cs_n` = 1.
- **Mid-range target (CODE_W=8):** model meas_val = code·100, target = 12800. Trial sequence must be 128, 192, 160, 144, 136, 132, 130, 129. Final code = 128 (equal keeps the bit). One `done` pulse. Nine SPI frames, each first byte 0x11.
- **Extremes:**
  - target = 0xFFFF → code = 255.
  - target = 0 with meas_val = code·100 + 1 → code = 0.
- **Timeout:** never assert `meas_ack` → `fail` = 1 exactly TIMEOUT cycles after `meas_req` rises; `busy` drops; no `done`. The next `start` clears `fail`.
- **Frame check:** SCLK_DIV = 2. Capture SDI on rising SCLK for code 0xA5 → 16'h11A5; `pot_cs_n` low for 64 cycles.
- **Robustness:** `start` pulsed while busy → ignored. `rst` asserted mid-frame → `pot_cs_n` = 1 next cycle, state IDLE.

Source files
------------

// File: rtl/gyrator_tune_ctrl.sv
// SAR tuning controller: trims the gyrator digipot code until the measured impedance meets the target.
// Latency: per trial 32*SCLK_DIV + SETTLE_CYCLES + measurement response + 1 cycles; the final write adds 32*SCLK_DIV.
// Backpressure: meas_req is held until meas_ack or TIMEOUT; start is ignored while busy.
module gyrator_tune_ctrl #(
    parameter int CODE_W        = 8,
    parameter int SETTLE_CYCLES = 64,
    parameter int SCLK_DIV      = 4,
    parameter int TIMEOUT       = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [15:0]       target,
    output logic              meas_req,
    input  logic              meas_ack,
    input  logic [15:0]       meas_val,
    output logic              pot_cs_n,
    output logic              pot_sclk,
    output logic              pot_sdi,
    output logic [CODE_W-1:0] code,
    output logic              busy,
    output logic              done,
    output logic              fail
);
    localparam int IDX_W = (CODE_W > 1) ? $clog2(CODE_W) : 1;
    localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + SETTLE_CYCLES + 1);

    localparam logic [IDX_W-1:0]  IDX_TOP   = IDX_W'(CODE_W - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCLK_DIV - 1);
    localparam logic [CNT_W-1:0]  SET_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [CODE_W-1:0] CODE_MID  = CODE_W'(1) << (CODE_W - 1);
    localparam logic [7:0]        FRAME_CMD = 8'h11;

    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_SETTLE, S_MEAS, S_DECIDE, S_DONE, S_FAIL
    } state_t;

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  bit_idx, idx_m1;
    logic [DIV_W-1:0]  div_cnt;
    logic [4:0]        tog_cnt;
    logic [CNT_W-1:0]  cnt;
    logic [15:0]       target_q, meas_q, frame_nxt;
    logic [14:0]       shreg;
    logic [CODE_W-1:0] code_nxt;
    logic [7:0]        code8;
    logic              final_q, sclk_tick, frame_end, write_entry;

    assign idx_m1      = bit_idx - IDX_W'(1);
    assign sclk_tick   = (div_cnt == DIV_LAST);
    assign frame_end   = sclk_tick && (tog_cnt == 5'd31);
    assign write_entry = (state != S_WRITE) && (state_nxt == S_WRITE);
    assign frame_nxt   = {FRAME_CMD, code8};

    // The pot register is 8 bits wide regardless of CODE_W.
    generate
        if (CODE_W >= 8) begin : g_trunc
            assign code8 = code_nxt[7:0];
        end else begin : g_ext
            assign code8 = {{(8 - CODE_W){1'b0}}, code_nxt};
        end
    endgenerate

    always_comb begin
        state_nxt = state;
        code_nxt  = code;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_WRITE;
                    code_nxt  = CODE_MID;
                end
            end
            S_WRITE:  if (frame_end) state_nxt = final_q ? S_DONE : S_SETTLE;
            S_SETTLE: if (cnt == SET_LAST) state_nxt = S_MEAS;
            S_MEAS: begin
                // An ack on the expiry cycle still wins over the timeout.
                if (meas_ack)           state_nxt = S_DECIDE;
                else if (cnt == TO_LAST) state_nxt = S_FAIL;
            end
            S_DECIDE: begin
                if (meas_q > target_q) code_nxt[bit_idx] = 1'b0;
                if (bit_idx != '0)     code_nxt[idx_m1]  = 1'b1;
                state_nxt = S_WRITE;
            end
            S_DONE, S_FAIL: state_nxt = S_IDLE;
            default:        state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            code     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            fail     <= 1'b0;
            meas_req <= 1'b0;
            pot_cs_n <= 1'b1;
            pot_sclk <= 1'b0;
            pot_sdi  <= 1'b0;
            final_q  <= 1'b0;
            bit_idx  <= '0;
            div_cnt  <= '0;
            tog_cnt  <= '0;
            cnt      <= '0;
            target_q <= '0;
            meas_q   <= '0;
            shreg    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        target_q <= target;
                        fail     <= 1'b0;
                        busy     <= 1'b1;
                        final_q  <= 1'b0;
                        bit_idx  <= IDX_TOP;
                        code     <= code_nxt;
                    end
                end
                S_WRITE: begin
                    div_cnt <= sclk_tick ? '0 : div_cnt + DIV_W'(1);
                    if (sclk_tick) begin
                        tog_cnt  <= tog_cnt + 5'd1;
                        pot_sclk <= ~pot_sclk;
                        if (pot_sclk) begin
                            pot_sdi <= shreg[14];
                            shreg   <= {shreg[13:0], 1'b0};
                        end
                        if (frame_end) begin
                            pot_cs_n <= 1'b1;
                            pot_sdi  <= 1'b0;
                            cnt      <= '0;
                        end
                    end
                end
                S_SETTLE: begin
                    if (cnt == SET_LAST) begin
                        cnt      <= '0;
                        meas_req <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_MEAS: begin
                    cnt <= cnt + CNT_W'(1);
                    if (meas_ack) begin
                        meas_req <= 1'b0;
                        meas_q   <= meas_val;
                    end else if (cnt == TO_LAST) begin
                        meas_req <= 1'b0;
                        fail     <= 1'b1;
                    end
                end
                S_DECIDE: begin
                    code <= code_nxt;
                    if (bit_idx == '0) final_q <= 1'b1;
                    else               bit_idx <= idx_m1;
                end
                S_DONE: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    final_q <= 1'b0;
                end
                S_FAIL:  busy <= 1'b0;
                default: ;
            endcase
            // Frame bit 15 is presented together with the falling chip select.
            if (write_entry) begin
                pot_cs_n <= 1'b0;
                pot_sclk <= 1'b0;
                div_cnt  <= '0;
                tog_cnt  <= '0;
                pot_sdi  <= frame_nxt[15];
                shreg    <= frame_nxt[14:0];
            end
        end
    end
endmodule
